// File: rtl/tone_det_pkg.sv
// Shared types and constants for the tone qualification path.
package tone_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_e;

    localparam int CNT_W = 16;

    typedef logic signed [19:0] sample_t;

endpackage

// File: rtl/zero_cross_hyst.sv
// Schmitt-trigger polarity tracker with rising-crossing strobe and saturated magnitude.
module zero_cross_hyst #(
    parameter int W    = 20,
    parameter int HYST = 1000
) (
    input  logic                ck_i,
    input  logic                rst_i,
    input  logic signed [W-1:0] in_i,
    input  logic                input_ready_i,
    output logic                pol_o,
    output logic                rise_o,
    output logic [W-1:0]        mag_o
);

    localparam logic signed [W-1:0] HYST_P = W'(HYST);
    localparam logic signed [W-1:0] HYST_N = W'(-HYST);
    localparam logic [W-1:0]        MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]        MOST_POS = {1'b0, {(W-1){1'b1}}};

    logic pol_q, pol_d;
    logic set_hi, set_lo;

    assign set_hi = (in_i >= HYST_P);
    assign set_lo = (in_i <= HYST_N);

    always_comb begin
        pol_d = pol_q;
        if (input_ready_i) begin
            if (set_hi) begin
                pol_d = 1'b1;
            end else if (set_lo) begin
                pol_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            pol_q <= 1'b0;
        end else begin
            pol_q <= pol_d;
        end
    end

    // The most negative code has no positive twin, so it clips to full scale.
    always_comb begin
        if (in_i == $signed(MOST_NEG)) begin
            mag_o = MOST_POS;
        end else if (in_i[W-1]) begin
            mag_o = W'(-in_i);
        end else begin
            mag_o = in_i;
        end
    end

    assign rise_o = input_ready_i && !pol_q && set_hi;
    assign pol_o  = pol_q;

endmodule

// File: rtl/tone_detector.sv
// Qualifies a filtered tone: measures period/amplitude per cycle and locks after
// CONFIRM consecutive in-spec cycles.
module tone_detector
    import tone_det_pkg::*;
#(
    parameter int W          = 20,
    parameter int THRESH     = 4000,
    parameter int HYST       = 1000,
    parameter int MIN_PERIOD = 4,
    parameter int MAX_PERIOD = 64,
    parameter int CONFIRM    = 4
) (
    input  logic                ck,
    input  logic                rst,
    input  logic signed [W-1:0] in,
    input  logic                input_ready,
    output logic [15:0]         period,
    output logic [W-1:0]        amplitude,
    output logic                measure_ready,
    output logic                detected
);

    localparam int CONF_W = $clog2(CONFIRM + 1);

    localparam logic [CNT_W-1:0]  MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  MAX_P    = CNT_W'(MAX_PERIOD);
    localparam logic [W-1:0]      THRESH_U = W'(THRESH);
    localparam logic [CONF_W-1:0] CONF_N   = CONF_W'(CONFIRM);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       peak_q, peak_d;
    logic [CONF_W-1:0]  conf_q, conf_d;
    logic [15:0]        period_q, period_d;
    logic [W-1:0]       amp_q, amp_d;
    logic               mrdy_q, mrdy_d;
    logic               det_q, det_d;

    logic               pol;
    logic               rise;
    logic [W-1:0]       mag;

    logic [CNT_W-1:0]   meas_p;
    logic [W-1:0]       meas_a;
    logic               cyc_valid;
    logic               timeout;
    logic [CONF_W-1:0]  conf_inc;

    zero_cross_hyst #(
        .W    (W),
        .HYST (HYST)
    ) u_zc (
        .ck_i          (ck),
        .rst_i         (rst),
        .in_i          (in),
        .input_ready_i (input_ready),
        .pol_o         (pol),
        .rise_o        (rise),
        .mag_o         (mag)
    );

    assign meas_p    = cnt_q + CNT_W'(1);
    assign meas_a    = (mag > peak_q) ? mag : peak_q;
    assign cyc_valid = (meas_p >= MIN_P) && (meas_p <= MAX_P) && (meas_a >= THRESH_U);
    assign timeout   = input_ready && !rise && (meas_p == MAX_P);
    assign conf_inc  = conf_q + CONF_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        peak_d   = peak_q;
        conf_d   = conf_q;
        period_d = period_q;
        amp_d    = amp_q;
        mrdy_d   = 1'b0;
        det_d    = det_q;

        if (input_ready) begin
            // IDLE has no timeout, so the counter parks at MAX_P there instead of wrapping.
            if (rise) begin
                cnt_d  = '0;
                peak_d = mag;
            end else begin
                cnt_d  = (cnt_q == MAX_P) ? cnt_q : meas_p;
                peak_d = meas_a;
            end

            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = MEASURE;
                        conf_d  = '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        mrdy_d   = 1'b1;
                        period_d = meas_p;
                        amp_d    = meas_a;
                        if (cyc_valid) begin
                            conf_d = conf_inc;
                            if (conf_inc == CONF_N) begin
                                state_d = LOCKED;
                                det_d   = 1'b1;
                            end
                        end else begin
                            conf_d = '0;
                        end
                    end else if (timeout) begin
                        state_d = IDLE;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        mrdy_d   = 1'b1;
                        period_d = meas_p;
                        amp_d    = meas_a;
                        if (!cyc_valid) begin
                            state_d = MEASURE;
                            conf_d  = '0;
                            det_d   = 1'b0;
                        end
                    end else if (timeout) begin
                        state_d = IDLE;
                        det_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    det_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            peak_q   <= '0;
            conf_q   <= '0;
            period_q <= '0;
            amp_q    <= '0;
            mrdy_q   <= 1'b0;
            det_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            conf_q   <= conf_d;
            period_q <= period_d;
            amp_q    <= amp_d;
            mrdy_q   <= mrdy_d;
            det_q    <= det_d;
        end
    end

    assign period        = period_q;
    assign amplitude     = amp_q;
    assign measure_ready = mrdy_q;
    assign detected      = det_q;

endmodule

// File: tb/tb_tone_detector.sv
// Randomized and directed check of tone_detector against a cycle-level behavioural model.
module tb_tone_detector;

    localparam int W          = 20;
    localparam int THRESH     = 4000;
    localparam int HYST       = 1000;
    localparam int MIN_PERIOD = 4;
    localparam int MAX_PERIOD = 64;
    localparam int CONFIRM    = 4;

    logic                ck = 1'b0;
    logic                rst;
    logic signed [W-1:0] in;
    logic                input_ready;
    logic [15:0]         period;
    logic [W-1:0]        amplitude;
    logic                measure_ready;
    logic                detected;

    int n_checks = 0;
    int n_err    = 0;
    int n_mrdy   = 0;

    // Behavioural model: "armed" means a first crossing has been seen since reset/timeout.
    bit m_pol, m_armed, m_locked, m_mrdy, m_det;
    int m_cnt, m_peak, m_conf, m_period, m_amp;

    tone_detector #(
        .W          (W),
        .THRESH     (THRESH),
        .HYST       (HYST),
        .MIN_PERIOD (MIN_PERIOD),
        .MAX_PERIOD (MAX_PERIOD),
        .CONFIRM    (CONFIRM)
    ) dut (
        .ck            (ck),
        .rst           (rst),
        .in            (in),
        .input_ready   (input_ready),
        .period        (period),
        .amplitude     (amplitude),
        .measure_ready (measure_ready),
        .detected      (detected)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task m_reset();
        m_pol = 0; m_armed = 0; m_locked = 0; m_mrdy = 0; m_det = 0;
        m_cnt = 0; m_peak = 0; m_conf = 0; m_period = 0; m_amp = 0;
    endtask

    task m_sample(input int s);
        int  m, p, a;
        bit  rise, ok;
        m    = (s < 0) ? -s : s;
        if (m > 524287) m = 524287;
        rise   = !m_pol && (s >= HYST);
        m_mrdy = 0;
        if (s >= HYST) m_pol = 1;
        else if (s <= -HYST) m_pol = 0;
        if (rise) begin
            p = m_cnt + 1;
            a = (m > m_peak) ? m : m_peak;
            if (m_armed) begin
                m_mrdy   = 1;
                m_period = p;
                m_amp    = a;
                ok = (p >= MIN_PERIOD) && (p <= MAX_PERIOD) && (a >= THRESH);
                if (!ok) begin
                    m_conf = 0; m_locked = 0; m_det = 0;
                end else if (!m_locked) begin
                    m_conf++;
                    if (m_conf >= CONFIRM) begin
                        m_locked = 1; m_det = 1;
                    end
                end
            end else begin
                m_armed = 1;
                m_conf  = 0;
            end
            m_cnt  = 0;
            m_peak = m;
        end else begin
            if (m_armed && (m_cnt + 1 >= MAX_PERIOD)) begin
                m_armed = 0; m_locked = 0; m_det = 0;
            end
            m_cnt++;
            if (m > m_peak) m_peak = m;
        end
    endtask

    task automatic step(input int s, input bit rdy, input bit r);
        @(negedge ck);
        in          = W'(s);
        input_ready = rdy;
        rst         = r;
        @(posedge ck);
        #1;
        if (r) m_reset();
        else if (rdy) m_sample(s);
        else m_mrdy = 0;
        if (measure_ready === 1'b1) n_mrdy++;
        chk("measure_ready", 32'(measure_ready), 32'(m_mrdy));
        chk("detected", 32'(detected), 32'(m_det));
        chk("period", 32'(period), 32'(m_period));
        chk("amplitude", 32'(amplitude), 32'(m_amp));
    endtask

    // One strobed sample, preceded by 0..2 idle cycles carrying junk data.
    task automatic strobe(input int s);
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            step($urandom_range(0, 40000) - 20000, 1'b0, 1'b0);
        end
        step(s, 1'b1, 1'b0);
    endtask

    task automatic sq(input int a, input int per, input int ncyc);
        int h;
        h = per / 2;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < per; i++) begin
                strobe((i < h) ? a : -a);
            end
        end
    endtask

    initial begin
        int pers[7];
        int amps[5];
        pers = '{2, 3, 4, 8, 20, 64, 65};
        amps = '{2000, 3999, 4000, 10000, 524287};
        rst = 1'b1; input_ready = 1'b0; in = '0;
        m_reset();

        // Reset with strobes pulsing: everything stays zero.
        step(10000, 1'b1, 1'b1);
        step(-10000, 1'b1, 1'b1);
        step(0, 1'b0, 1'b0);
        chk("reset_det", 32'(detected), 32'd0);
        chk("reset_amp", 32'(amplitude), 32'd0);

        // +-10000, 8 samples/cycle: 3 measurements after 4 cycles, lock on the 4th.
        n_mrdy = 0;
        sq(10000, 8, 4);
        chk("sq10k_mrdy3", 32'(n_mrdy), 32'd3);
        chk("sq10k_nodet", 32'(detected), 32'd0);
        sq(10000, 8, 1);
        chk("sq10k_mrdy4", 32'(n_mrdy), 32'd4);
        chk("sq10k_det", 32'(detected), 32'd1);
        chk("sq10k_period", 32'(period), 32'd8);
        chk("sq10k_amp", 32'(amplitude), 32'd10000);

        // Full-scale negative sample inside a valid cycle clips to 524287.
        strobe(10000); strobe(10000); strobe(10000); strobe(10000);
        strobe(-10000); strobe(-524288); strobe(-10000); strobe(-10000);
        strobe(10000);
        chk("clip_mrdy", 32'(measure_ready), 32'd1);
        chk("clip_amp", 32'(amplitude), 32'd524287);
        chk("clip_det", 32'(detected), 32'd1);

        // Hold +10000 after locking: timeout drops the lock.
        for (int i = 0; i < 62; i++) strobe(10000);
        chk("hold62_det", 32'(detected), 32'd1);
        strobe(10000); strobe(10000);
        chk("hold64_det", 32'(detected), 32'd0);
        chk("hold_period_kept", 32'(period), 32'd8);
        for (int i = 0; i < 4; i++) strobe(-10000);
        n_mrdy = 0;
        sq(10000, 8, 1);
        chk("rearm_no_mrdy", 32'(n_mrdy), 32'd0);
        strobe(10000);
        chk("rearm_mrdy", 32'(n_mrdy), 32'd1);
        chk("rearm_period", 32'(period), 32'd8);
        for (int i = 0; i < 3; i++) strobe(10000);
        for (int i = 0; i < 4; i++) strobe(-10000);

        // Noise inside the hysteresis band never crosses.
        n_mrdy = 0;
        for (int i = 0; i < 40; i++) strobe($urandom_range(0, 1800) - 900);
        chk("noise_mrdy", 32'(n_mrdy), 32'd0);

        // Low-amplitude tone measures but never qualifies.
        step(0, 1'b0, 1'b1);
        n_mrdy = 0;
        sq(2000, 8, 6);
        chk("sq2k_mrdy", 32'(n_mrdy), 32'd5);
        chk("sq2k_period", 32'(period), 32'd8);
        chk("sq2k_amp", 32'(amplitude), 32'd2000);
        chk("sq2k_det", 32'(detected), 32'd0);

        // Lock, then reset on a crossing strobe; re-lock needs 1 + CONFIRM crossings.
        sq(10000, 8, 5);
        chk("prelock_det", 32'(detected), 32'd1);
        step(10000, 1'b1, 1'b1);
        chk("rst_cross_det", 32'(detected), 32'd0);
        chk("rst_cross_mrdy", 32'(measure_ready), 32'd0);
        chk("rst_cross_period", 32'(period), 32'd0);
        for (int i = 0; i < 4; i++) strobe(-10000);
        sq(10000, 8, 4);
        chk("relock_pending", 32'(detected), 32'd0);
        strobe(10000);
        chk("relock_det", 32'(detected), 32'd1);
        for (int i = 0; i < 3; i++) strobe(10000);
        for (int i = 0; i < 4; i++) strobe(-10000);

        // Randomized tones around the period and amplitude limits.
        for (int t = 0; t < 14; t++) begin
            sq(amps[$urandom_range(0, 4)], pers[$urandom_range(0, 6)], $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 10; i++) strobe($urandom_range(0, 1800) - 900);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
